// File: rtl/fwd_hazard_scoreboard.sv
// Operand forwarding and load-use hazard unit for the 5-stage pipeline.
// Optional hazard statistics counters are built when HAZARD_STATS_EN is defined.
module fwd_hazard_scoreboard #(
  parameter int REG_ADDR_W = 4,
  parameter int DATA_W     = 32,
  parameter int NUM_SRC    = 3,
  parameter int FWD_DEPTH  = 3,
  parameter int PC_REG     = 15,
  localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          id_valid,
  input  logic                          id_rf_e,
  input  logic                          id_load,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic                          flush,
  input  logic [NUM_SRC*DATA_W-1:0]     rf_data,
  input  logic [FWD_DEPTH*DATA_W-1:0]   stage_data,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic [NUM_SRC*DATA_W-1:0]     op_data,
  output logic                          stall,
  output logic                          nop_ex
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]                   stall_count,
  output logic [15:0]                   fwd_count
`endif
);

  localparam logic [REG_ADDR_W-1:0] PC_ADDR = REG_ADDR_W'(PC_REG);

  typedef struct packed {
    logic                  valid;
    logic                  rf_e;
    logic                  load;
    logic [REG_ADDR_W-1:0] rd;
  } entry_t;

  entry_t [FWD_DEPTH-1:0]                ent_q, ent_d;
  logic   [NUM_SRC-1:0][FWD_DEPTH-1:0]   match;
  logic   [NUM_SRC-1:0]                  hazard;
  logic   [NUM_SRC-1:0][SEL_W-1:0]       sel;

  // Tag comparison of every source against every in-flight destination.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    match = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int i = 0; i < FWD_DEPTH; i++) begin
        match[s][i] = id_src_used[s]
                   && ent_q[i].valid
                   && ent_q[i].rf_e
                   && (ent_q[i].rd == id_src_addr[s*REG_ADDR_W +: REG_ADDR_W])
                   && (id_src_addr[s*REG_ADDR_W +: REG_ADDR_W] != PC_ADDR);
      end
    end
  end

  // Scanning oldest to youngest lets the youngest match overwrite older ones.
  always_comb begin
    sel     = '0;
    hazard  = '0;
    op_data = rf_data;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
        if (match[s][i]) sel[s] = SEL_W'(i + 1);
      end
      // A load still in EX has no data yet; the instruction stalls instead.
      if (match[s][0] && ent_q[0].load) begin
        hazard[s] = 1'b1;
        sel[s]    = '0;
      end
      for (int i = 0; i < FWD_DEPTH; i++) begin
        if (sel[s] == SEL_W'(i + 1)) begin
          op_data[s*DATA_W +: DATA_W] = stage_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign fwd_sel = sel;
  assign stall   = id_valid && !flush && (|hazard);
  assign nop_ex  = stall || flush;

  always_comb begin
    ent_d = '0;
    if (id_valid && !stall && !flush) begin
      ent_d[0].valid = 1'b1;
      ent_d[0].rf_e  = id_rf_e;
      ent_d[0].load  = id_load;
      ent_d[0].rd    = id_rd;
    end
    for (int i = 1; i < FWD_DEPTH; i++) begin
      ent_d[i] = ent_q[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages shift from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ent_q <= '0;
    else       ent_q <= ent_d;
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count_q, stall_count_d;
  logic [15:0] fwd_count_q,   fwd_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    fwd_count_d   = fwd_count_q;
    if (stall && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
    if ((|sel) && (fwd_count_q != 16'hFFFF))  fwd_count_d   = fwd_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= '0;
      fwd_count_q   <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      fwd_count_q   <= fwd_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign fwd_count   = fwd_count_q;
`endif

endmodule
